// File: rtl/systolic_array_pkg.sv
// Shared types and default parameters for the systolic array processing elements.
package systolic_array_pkg;

    typedef enum logic {
        EMPTY,
        ACCUM
    } pe_acc_state_t;

    localparam int unsigned PE_DATA_W     = 8;
    localparam int unsigned PE_ACC_W      = 32;
    localparam int unsigned PE_MUL_STAGES = 2;
    localparam int unsigned PE_K_MAX      = 256;

endpackage

// File: rtl/pe_mul_pipe.sv
// Signed multiplier followed by STAGES enabled registers; valid and last travel with the product.
module pe_mul_pipe
    import systolic_array_pkg::*;
#(
    parameter int unsigned DATA_W = PE_DATA_W,
    parameter int unsigned STAGES = PE_MUL_STAGES
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       en,
    input  logic signed [DATA_W-1:0]   x_i,
    input  logic signed [DATA_W-1:0]   w_i,
    input  logic                       valid_i,
    input  logic                       last_i,
    output logic signed [2*DATA_W-1:0] prod_o,
    output logic                       valid_o,
    output logic                       last_o
);
    localparam int unsigned PW = 2 * DATA_W;

    logic signed [PW-1:0] prod_q [STAGES];
    logic signed [PW-1:0] prod_d [STAGES];
    logic [STAGES-1:0]    valid_q, valid_d;
    logic [STAGES-1:0]    last_q, last_d;

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            prod_d[s] = prod_q[s];
        end
        valid_d = valid_q;
        last_d  = last_q;
        if (en) begin
            prod_d[0]  = PW'(x_i) * PW'(w_i);
            valid_d[0] = valid_i;
            last_d[0]  = valid_i && last_i;
            for (int s = 1; s < STAGES; s++) begin
                prod_d[s]  = prod_q[s-1];
                valid_d[s] = valid_q[s-1];
                last_d[s]  = last_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int s = 0; s < STAGES; s++) begin
                prod_q[s] <= '0;
            end
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                prod_q[s] <= prod_d[s];
            end
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign prod_o  = prod_q[STAGES-1];
    assign valid_o = valid_q[STAGES-1];
    assign last_o  = last_q[STAGES-1];

endmodule

// File: rtl/systolic_pe_acc.sv
// Output-stationary systolic PE: pipelined signed MAC, operand forwarding, one-deep result slot.
// Define PE_SAT_EN for saturating accumulation with a sticky per-result overflow flag.
module systolic_pe_acc
    import systolic_array_pkg::*;
#(
    parameter int unsigned DATA_W     = PE_DATA_W,
    parameter int unsigned ACC_W      = PE_ACC_W,
    parameter int unsigned MUL_STAGES = PE_MUL_STAGES,
    parameter int unsigned K_MAX      = PE_K_MAX
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] w_i,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     stall,
    output logic signed [DATA_W-1:0] x_o,
    output logic signed [DATA_W-1:0] w_o,
    output logic                     fwd_valid,
    output logic signed [ACC_W-1:0]  psum_o,
    output logic                     psum_valid,
    input  logic                     psum_ready,
    output logic                     ovf_o
);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = $clog2(K_MAX + 1);

    logic                     en, accept, close;
    logic signed [PROD_W-1:0] mul_prod;
    logic                     mul_valid, mul_last;
    logic signed [ACC_W-1:0]  prod_ext, step_sum, acc_new;
    logic signed [ACC_W-1:0]  acc_q, acc_d, psum_q, psum_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_new;
    logic signed [DATA_W-1:0] x_fwd_q, x_fwd_d, w_fwd_q, w_fwd_d;
    logic                     fwd_valid_q, fwd_valid_d, psum_valid_q, psum_valid_d;
    pe_acc_state_t            state_q, state_d;

    // A held result blocks everything, so no beat can overwrite it.
    assign stall  = psum_valid_q && !psum_ready;
    assign en     = !stall;
    assign accept = in_valid && en;

    pe_mul_pipe #(
        .DATA_W (DATA_W),
        .STAGES (MUL_STAGES)
    ) u_mul (
        .clk     (clk),
        .n_rst   (n_rst),
        .en      (en),
        .x_i     (x_i),
        .w_i     (w_i),
        .valid_i (accept),
        .last_i  (in_last),
        .prod_o  (mul_prod),
        .valid_o (mul_valid),
        .last_o  (mul_last)
    );

    assign prod_ext = ACC_W'(mul_prod);

`ifdef PE_SAT_EN
    logic signed [ACC_W:0] sum_wide;
    logic                  step_ovf, ovf_new, ovf_acc_q, ovf_acc_d, ovf_q, ovf_d;

    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
        step_ovf = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        if (!step_ovf) begin
            step_sum = sum_wide[ACC_W-1:0];
        end else if (sum_wide[ACC_W]) begin
            step_sum = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            step_sum = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign step_sum = acc_q + prod_ext;
`endif

    always_comb begin
        x_fwd_d      = x_fwd_q;
        w_fwd_d      = w_fwd_q;
        fwd_valid_d  = fwd_valid_q;
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        psum_d       = psum_q;
        psum_valid_d = psum_valid_q;
        close        = 1'b0;
        acc_new      = step_sum;
        cnt_new      = cnt_q + 1'b1;
`ifdef PE_SAT_EN
        ovf_acc_d    = ovf_acc_q;
        ovf_d        = ovf_q;
        ovf_new      = ovf_acc_q | step_ovf;
`endif
        if (state_q == EMPTY) begin
            acc_new = prod_ext;
            cnt_new = CNT_W'(1);
`ifdef PE_SAT_EN
            ovf_new = 1'b0;
`endif
        end
        if (en) begin
            fwd_valid_d = accept;
            if (accept) begin
                x_fwd_d = x_i;
                w_fwd_d = w_i;
            end
            if (psum_valid_q && psum_ready) begin
                psum_valid_d = 1'b0;
            end
            if (mul_valid) begin
                close = mul_last || (cnt_new == CNT_W'(K_MAX));
                if (close) begin
                    state_d      = EMPTY;
                    acc_d        = '0;
                    cnt_d        = '0;
                    psum_d       = acc_new;
                    psum_valid_d = 1'b1;
`ifdef PE_SAT_EN
                    ovf_d        = ovf_new;
                    ovf_acc_d    = 1'b0;
`endif
                end else begin
                    state_d = ACCUM;
                    acc_d   = acc_new;
                    cnt_d   = cnt_new;
`ifdef PE_SAT_EN
                    ovf_acc_d = ovf_new;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_fwd_q      <= '0;
            w_fwd_q      <= '0;
            fwd_valid_q  <= 1'b0;
            state_q      <= EMPTY;
            acc_q        <= '0;
            cnt_q        <= '0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
`ifdef PE_SAT_EN
            ovf_acc_q    <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            x_fwd_q      <= x_fwd_d;
            w_fwd_q      <= w_fwd_d;
            fwd_valid_q  <= fwd_valid_d;
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
`ifdef PE_SAT_EN
            ovf_acc_q    <= ovf_acc_d;
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign x_o        = x_fwd_q;
    assign w_o        = w_fwd_q;
    assign fwd_valid  = fwd_valid_q;
    assign psum_o     = psum_q;
    assign psum_valid = psum_valid_q;
`ifdef PE_SAT_EN
    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_pe_acc.sv
// Randomised bench for systolic_pe_acc against a queue-based dot-product reference model.
module tb_systolic_pe_acc;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;
    localparam int unsigned MS = 2;
    localparam int unsigned KM = 4;

    logic                 clk        = 1'b0;
    logic                 n_rst      = 1'b0;
    logic signed [DW-1:0] x_i        = '0;
    logic signed [DW-1:0] w_i        = '0;
    logic                 in_valid   = 1'b0;
    logic                 in_last    = 1'b0;
    logic                 psum_ready = 1'b1;
    logic                 stall, fwd_valid, psum_valid, ovf_o;
    logic signed [DW-1:0] x_o, w_o;
    logic signed [AW-1:0] psum_o;

    always #5 clk = ~clk;

    systolic_pe_acc #(
        .DATA_W     (DW),
        .ACC_W      (AW),
        .MUL_STAGES (MS),
        .K_MAX      (KM)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .x_i        (x_i),
        .w_i        (w_i),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .stall      (stall),
        .x_o        (x_o),
        .w_o        (w_o),
        .fwd_valid  (fwd_valid),
        .psum_o     (psum_o),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .ovf_o      (ovf_o)
    );

    typedef struct {
        logic signed [DW-1:0] x;
        logic signed [DW-1:0] w;
        logic                 last;
    } beat_t;

    typedef struct {
        longint sum;
        bit     ovf;
        int     cyc;
    } res_t;

    beat_t       src_q[$];
    res_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_drained = 0;
    int unsigned gap_pct  = 0;
    int unsigned rdy_pct  = 0;
    bit          chk_lat  = 1'b0;
    bit          acc_seen = 1'b0;
    longint      cur_sum  = 0;
    int          cur_cnt  = 0;
    bit          cur_ovf  = 1'b0;
    longint      exp_x    = 0;
    longint      exp_w    = 0;
    bit          exp_fv   = 1'b0;
    longint      last_psum = 0;
    bit          last_ovf  = 1'b0;
    longint      mon_p;
    bit          mon_o;
    res_t        mon_r;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reduce an exact sum to the accumulator's range: clamp or wrap.
    function automatic longint fold(input longint v, output bit ovf);
        longint maxv = (longint'(1) <<< (AW - 1)) - 1;
        longint minv = -(longint'(1) <<< (AW - 1));
        longint m;
        ovf = 1'b0;
`ifdef PE_SAT_EN
        m = v;
        if (v > maxv) begin
            ovf = 1'b1;
            m = maxv;
        end else if (v < minv) begin
            ovf = 1'b1;
            m = minv;
        end
`else
        m = v & ((longint'(1) <<< AW) - 1);
        if (m > maxv) m = m - (longint'(1) <<< AW);
        if (minv > m) m = minv;
`endif
        return m;
    endfunction

    task automatic push_beat(input int x, input int w, input bit last);
        beat_t b;
        b.x = DW'(x);
        b.w = DW'(w);
        b.last = last;
        src_q.push_back(b);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0 || cur_cnt != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_timeout"}, longint'(n < budget), 1);
        repeat (2) @(negedge clk);
    endtask

    // Driver: present queued beats, hold them until accepted, randomise psum_ready.
    always @(posedge clk) begin
        #1;
        if (!n_rst) begin
            in_valid   = 1'b0;
            psum_ready = 1'b1;
        end else begin
            if (in_valid && acc_seen) void'(src_q.pop_front());
            if (!(in_valid && !acc_seen)) begin
                if (src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                    in_valid = 1'b1;
                    x_i      = src_q[0].x;
                    w_i      = src_q[0].w;
                    in_last  = src_q[0].last;
                end else begin
                    in_valid = 1'b0;
                    x_i      = DW'($urandom);
                    w_i      = DW'($urandom);
                    in_last  = 1'($urandom);
                end
            end
            psum_ready = ($urandom_range(99) >= rdy_pct);
        end
    end

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!n_rst) begin
            check_eq("rst_x_o", longint'(x_o), 0);
            check_eq("rst_w_o", longint'(w_o), 0);
            check_eq("rst_fwd_valid", longint'(fwd_valid), 0);
            check_eq("rst_psum_o", longint'(psum_o), 0);
            check_eq("rst_psum_valid", longint'(psum_valid), 0);
            check_eq("rst_ovf_o", longint'(ovf_o), 0);
            check_eq("rst_stall", longint'(stall), 0);
            exp_q.delete();
            cur_cnt  = 0;
            cur_sum  = 0;
            acc_seen = 1'b0;
            exp_fv   = 1'b0;
            exp_x    = 0;
            exp_w    = 0;
        end else begin
            check_eq("stall", longint'(stall), longint'(psum_valid && !psum_ready));
            check_eq("fwd_valid", longint'(fwd_valid), longint'(exp_fv));
            check_eq("x_o", longint'(x_o), exp_x);
            check_eq("w_o", longint'(w_o), exp_w);
            if (psum_valid && psum_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("psum_extra", longint'(exp_q.size()), 1);
                end else begin
                    mon_r = exp_q.pop_front();
                    check_eq("psum_o", longint'(psum_o), mon_r.sum);
                    check_eq("ovf_o", longint'(ovf_o), longint'(mon_r.ovf));
                    if (chk_lat) check_eq("latency", longint'(cyc - mon_r.cyc), longint'(MS + 1));
                end
                last_psum = longint'(psum_o);
                last_ovf  = ovf_o;
                n_drained++;
            end
            acc_seen = in_valid && !stall;
            if (acc_seen) begin
                mon_p = longint'(x_i) * longint'(w_i);
                if (cur_cnt == 0) begin
                    cur_sum = mon_p;
                    cur_ovf = 1'b0;
                end else begin
                    cur_sum = fold(cur_sum + mon_p, mon_o);
                    cur_ovf = cur_ovf | mon_o;
                end
                cur_cnt++;
                if (in_last || cur_cnt == int'(KM)) begin
                    exp_q.push_back('{sum: cur_sum, ovf: cur_ovf, cyc: cyc});
                    cur_cnt = 0;
                end
                exp_x  = longint'(x_i);
                exp_w  = longint'(w_i);
                exp_fv = 1'b1;
            end else if (!stall) begin
                exp_fv = 1'b0;
            end
        end
    end

    initial begin
        int n;
        int len;
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b1;

        chk_lat = 1'b1;
        push_beat(3, 4, 0);
        push_beat(-2, 5, 0);
        push_beat(7, -1, 1);
        wait_idle("dot", 50);
        check_eq("dot_value", last_psum, -5);

        n = n_drained;
        for (int i = 0; i < 6; i++) push_beat(1, 1, i == 5);
        wait_idle("kmax", 60);
        check_eq("kmax_results", longint'(n_drained - n), 2);
        check_eq("kmax_second", last_psum, 2);

        for (int i = 0; i < 3; i++) push_beat(127, 127, i == 2);
        wait_idle("ovf", 50);
`ifdef PE_SAT_EN
        check_eq("ovf_value", last_psum, 32767);
        check_eq("ovf_flag", longint'(last_ovf), 1);
`else
        check_eq("ovf_value", last_psum, -17149);
        check_eq("ovf_flag", longint'(last_ovf), 0);
`endif

        // Back-pressure: result held, second product must wait with no beat lost.
        chk_lat = 1'b0;
        rdy_pct = 100;
        push_beat(5, -6, 0);
        push_beat(4, 4, 0);
        push_beat(-3, 2, 1);
        repeat (12) @(negedge clk);
        check_eq("bp_stall", longint'(stall), 1);
        check_eq("bp_psum_valid", longint'(psum_valid), 1);
        push_beat(9, 9, 0);
        push_beat(-8, 7, 0);
        push_beat(1, -1, 1);
        repeat (12) @(negedge clk);
        check_eq("bp_hold", longint'(src_q.size()), 3);
        rdy_pct = 0;
        wait_idle("bp", 100);
        check_eq("bp_second", last_psum, 81 - 56 - 1);

        // Reset after two of three beats; nothing of that product may survive.
        chk_lat = 1'b1;
        push_beat(1, 2, 0);
        push_beat(3, 4, 0);
        push_beat(5, 6, 1);
        n = 0;
        while (src_q.size() > 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_wait_timeout", longint'(n < 50), 1);
        #2 n_rst = 1'b0;
        src_q.delete();
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b1;
        n = n_drained;
        push_beat(2, 3, 1);
        wait_idle("rst", 50);
        check_eq("rst_value", last_psum, 6);
        check_eq("rst_results", longint'(n_drained - n), 1);

        // Random products with input gaps and random back-pressure.
        chk_lat = 1'b0;
        gap_pct = 25;
        rdy_pct = 35;
        for (int p = 0; p < 40; p++) begin
            len = int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
                push_beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                          b == len - 1);
            end
        end
        wait_idle("rand", 4000);

        // One-beat products at full rate: one result per cycle at fixed latency.
        chk_lat = 1'b1;
        gap_pct = 0;
        rdy_pct = 0;
        for (int p = 0; p < 24; p++) begin
            push_beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, 1);
        end
        wait_idle("b2b", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule

// File: doc/systolic_pe_acc.md
# systolic_pe_acc

Parametrised output-stationary processing element for the systolic array, successor to the fixed fp32 PE. Each PE consumes a stream of signed activation/weight pairs, multiplies through a configurable-depth pipeline and accumulates a dot product of arbitrary length up to K_MAX. It forwards operands one cycle later to its east/south neighbours and presents each finished sum on a one-deep valid/ready output with back-pressure.

## Interface
- DATA_W, 8: signed operand width for x and w.
- ACC_W, 32: signed accumulator and result width; must be ≥ 2*DATA_W.
- MUL_STAGES, 2: multiplier pipeline register stages; legal range 1..4.
- K_MAX, 256: maximum beats per dot product; beat counter width is $clog2(K_MAX+1).
- clk  in  1  clock.
- n_rst  in  1  asynchronous, active-low reset.
- x_i  in  DATA_W  activation from the west.
- w_i  in  DATA_W  weight from the north.
- in_valid  in  1  x_i/w_i beat valid.
- in_last  in  1  beat is the final element of the current dot product.
- stall  out  1  beat not accepted this cycle; upstream holds x_i, w_i, in_valid and in_last.
- x_o  out  DATA_W  registered x_i to the east.
- w_o  out  DATA_W  registered w_i to the south.
- fwd_valid  out  1  x_o/w_o valid.
- psum_o  out  ACC_W  finished dot product.
- psum_valid  out  1  psum_o holds an unconsumed result.
- psum_ready  in  1  consumer accepts psum_o.
- ovf_o  out  1  sticky overflow of the result currently held on psum_o.

## Operation
- Accept: a beat is accepted when in_valid && !stall.
- Stall: stall = psum_valid && !psum_ready. This is a global enable: while stall is high, every pipeline register, the accumulator, the counter and the forwarding registers hold.
- Forwarding: on accept, x_o/w_o load x_i/w_i and fwd_valid <= 1. On a non-stalled cycle with no accept, fwd_valid <= 0 and x_o/w_o hold.
- Multiply: product = signed x_i * signed w_i, 2*DATA_W bits. It travels with its valid and last bits through MUL_STAGES registers.
- Accumulator FSM (product-valid stage):
  - EMPTY: on valid, acc <= sext(product), cnt <= 1, go to ACCUM.
  - ACCUM: on valid, acc <= acc + sext(product), cnt++.
  - Close: a valid product with last set, or with cnt reaching K_MAX (forced close), loads the final sum into the psum register, sets psum_valid and returns to EMPTY.
  - Back-to-back: a beat that closes one product and the following beat starting the next are handled without a bubble.
- Output: psum_valid clears on psum_valid && psum_ready. A new close in the same cycle as a drain reloads psum_o and keeps psum_valid high.
- Arithmetic: two's-complement, wrap modulo 2^ACC_W (see Configuration).
- in_last is ignored when in_valid is low.
- Reset, including mid-operation: FSM goes to EMPTY and all in-flight beats are discarded. x_o = 0, w_o = 0, fwd_valid = 0, psum_o = 0, psum_valid = 0, ovf_o = 0, stall = 0, acc = 0, cnt = 0.

## Timing
- Forward latency is 1 cycle: accept at cycle t gives x_o/w_o/fwd_valid at t+1.
- Result latency: the last beat accepted at cycle t gives psum_valid at t+MUL_STAGES+1, with no stall.
- Stall is combinational from psum_valid and psum_ready; it has no path from in_valid.
- Throughput is one beat per cycle when psum_ready is held high. A one-beat dot product every cycle yields one result per cycle.
- Each stalled cycle adds exactly one cycle to all latencies.

## Configuration
- PE_SAT_EN defined: each accumulate step saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. On clamp, an overflow flag is set for the current dot product and transfers to ovf_o with psum_o at close. It clears when the next dot product starts.
- PE_SAT_EN undefined: the accumulate wraps and ovf_o is tied to 0.

## Structure
- systolic_array_pkg gets:
  - typedef pe_acc_state_t {EMPTY, ACCUM}.
  - Default parameter constants PE_DATA_W, PE_ACC_W, PE_MUL_STAGES, PE_K_MAX.
- Sub-module pe_mul_pipe: signed multiplier plus MUL_STAGES registers with enable, carrying valid and last alongside the product.

## Test plan
- Dot product: DATA_W=8, ACC_W=32, MUL_STAGES=2, psum_ready=1; beats (3,4), (-2,5), (7,-1) with last on the third -> psum_o = -5 with psum_valid for one cycle, 3 cycles after the last beat is accepted.
- Back-pressure: psum_ready=0 after the first result, then stream a second dot product -> stall rises the cycle psum_valid is high. Inputs, x_o and the pipeline hold. Release psum_ready -> second result correct, no beat lost or duplicated.
- Forced close: K_MAX=4, 6 beats of (1,1) with last on beat 6 -> results 4 then 2.
- Overflow: ACC_W=16, 3 beats of (127,127) = 48387 total -> without PE_SAT_EN psum_o = -17149 and ovf_o = 0. With PE_SAT_EN psum_o = 32767 and ovf_o = 1.
- Reset mid-stream: drop n_rst after 2 of 3 beats, then send (2,3) with last -> psum_o = 6, no residue. All outputs are 0 during reset.
- Forwarding: send a random valid pattern -> x_o/w_o/fwd_valid equal the accepted beats delayed by 1 cycle, and hold during stall.
